// File: rtl/vram_write_port.sv
// CPU-facing write front end for the video/tile memory: a pointer/step register
// pair feeds a small address+data queue that drains only on granted cycles.
module vram_write_port #(
    parameter int ADDRESS_WIDTH   = 10,
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [1:0]                 cpu_reg_i,
    input  logic [7:0]                 cpu_data_i,
    input  logic                       cpu_write_i,
    input  logic                       mem_grant_i,
    output logic [ADDRESS_WIDTH-1:0]   mem_write_addr_o,
    output logic                       mem_write_enable_o,
    output logic [DATA_WIDTH-1:0]      mem_write_data_o,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_count_o,
    output logic                       busy_o,
    output logic                       overflow_o
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

    localparam logic [1:0] REG_ADDR_LO = 2'd0;
    localparam logic [1:0] REG_ADDR_HI = 2'd1;
    localparam logic [1:0] REG_DATA    = 2'd2;
    localparam logic [1:0] REG_STEP    = 2'd3;

    logic [ADDRESS_WIDTH-1:0]   ptr_q, ptr_d;
    logic [7:0]                 step_q, step_d;
    logic                       overflow_q, overflow_d;
    logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
    logic [FIFO_DEPTH_LOG2-1:0] wr_idx_q, wr_idx_d;
    logic [FIFO_DEPTH_LOG2-1:0] rd_idx_q, rd_idx_d;
    logic [ADDRESS_WIDTH-1:0]   waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic                       we_q, we_d;

    logic [ADDRESS_WIDTH-1:0]   fifo_addr_q [DEPTH];
    logic [DATA_WIDTH-1:0]      fifo_data_q [DEPTH];

    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;

    // Count never exceeds DEPTH, so its MSB alone marks the full state.
    assign full  = count_q[FIFO_DEPTH_LOG2];
    assign empty = (count_q == '0);
    assign pop   = ~empty & mem_grant_i;

    always_comb begin
        ptr_d      = ptr_q;
        step_d     = step_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        if (cpu_write_i) begin
            case (cpu_reg_i)
                REG_ADDR_LO: begin
                    ptr_d[7:0] = cpu_data_i;
                    overflow_d = 1'b0;
                end
                REG_ADDR_HI: ptr_d[ADDRESS_WIDTH-1:8] = cpu_data_i[ADDRESS_WIDTH-9:0];
                REG_STEP:    step_d = cpu_data_i;
                REG_DATA: begin
                    // Fullness is judged before any same-cycle pop.
                    if (full) begin
                        overflow_d = 1'b1;
                    end else begin
                        push  = 1'b1;
                        ptr_d = ptr_q + {{(ADDRESS_WIDTH-8){1'b0}}, step_q};
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        count_d  = count_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        we_d     = pop;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        if (push) begin
            wr_idx_d = wr_idx_q + 1'b1;
        end
        if (pop) begin
            rd_idx_d = rd_idx_q + 1'b1;
            waddr_d  = fifo_addr_q[rd_idx_q];
            wdata_d  = fifo_data_q[rd_idx_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_q      <= '0;
            step_q     <= 8'd1;
            overflow_q <= 1'b0;
            count_q    <= '0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            step_q     <= step_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Queue storage needs no reset: the indices and count define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr_q[wr_idx_q] <= ptr_q;
            fifo_data_q[wr_idx_q] <= cpu_data_i;
        end
    end

    assign mem_write_addr_o   = waddr_q;
    assign mem_write_enable_o = we_q;
    assign mem_write_data_o   = wdata_q;
    assign fifo_count_o       = count_q;
    assign busy_o             = (count_q != '0);
    assign overflow_o         = overflow_q;

endmodule

// File: tb/tb_vram_write_port.sv
// Scoreboard bench for vram_write_port: expected memory writes are queued as
// DATA writes are issued and checked as write-enable pulses appear.
module tb_vram_write_port;

    logic       clk_i;
    logic       reset_n_i;
    logic [1:0] cpu_reg_i;
    logic [7:0] cpu_data_i;
    logic       cpu_write_i;
    logic       mem_grant_i;
    logic [9:0] mem_write_addr_o;
    logic       mem_write_enable_o;
    logic [7:0] mem_write_data_o;
    logic [2:0] fifo_count_o;
    logic       busy_o;
    logic       overflow_o;

    typedef struct packed {
        logic [9:0] a;
        logic [7:0] d;
    } entry_t;

    entry_t     sbq[$];
    entry_t     exp_e;
    int         errors = 0;
    int         checks = 0;
    int         pulses = 0;
    logic [9:0] model_ptr = 10'h000;
    logic [7:0] model_step = 8'h01;

    vram_write_port #(
        .ADDRESS_WIDTH(10),
        .DATA_WIDTH(8),
        .FIFO_DEPTH_LOG2(2)
    ) dut (
        .clk_i(clk_i),
        .reset_n_i(reset_n_i),
        .cpu_reg_i(cpu_reg_i),
        .cpu_data_i(cpu_data_i),
        .cpu_write_i(cpu_write_i),
        .mem_grant_i(mem_grant_i),
        .mem_write_addr_o(mem_write_addr_o),
        .mem_write_enable_o(mem_write_enable_o),
        .mem_write_data_o(mem_write_data_o),
        .fifo_count_o(fifo_count_o),
        .busy_o(busy_o),
        .overflow_o(overflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Every pulse must match the oldest outstanding expected write.
    always @(posedge clk_i) begin
        #1;
        if (reset_n_i && mem_write_enable_o) begin
            pulses++;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got addr=%h data=%h, required no pulse",
                         mem_write_addr_o, mem_write_data_o);
            end else begin
                exp_e = sbq.pop_front();
                if ({mem_write_addr_o, mem_write_data_o} !== exp_e) begin
                    errors++;
                    $display("FAIL mem_write: got addr=%h data=%h, required addr=%h data=%h",
                             mem_write_addr_o, mem_write_data_o, exp_e.a, exp_e.d);
                end
            end
        end
    end

    task automatic cpu_wr(input logic [1:0] r, input logic [7:0] d, input bit accepted);
        @(negedge clk_i);
        cpu_reg_i   = r;
        cpu_data_i  = d;
        cpu_write_i = 1'b1;
        case (r)
            2'd0: model_ptr[7:0] = d;
            2'd1: model_ptr[9:8] = d[1:0];
            2'd3: model_step = d;
            default: if (accepted) begin
                sbq.push_back('{a: model_ptr, d: d});
                model_ptr = model_ptr + {2'b00, model_step};
            end
        endcase
        @(negedge clk_i);
        cpu_write_i = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk_i);
            #2;
            if (sbq.size() == 0 && busy_o === 1'b0 && mem_write_enable_o === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n_i   = 1'b0;
        cpu_reg_i   = 2'd0;
        cpu_data_i  = 8'h00;
        cpu_write_i = 1'b0;
        mem_grant_i = 1'b0;
        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        checks++;
        if (mem_write_enable_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_we: got %b, required 0", mem_write_enable_o);
        end
        checks++;
        if (mem_write_addr_o !== 10'h000 || mem_write_data_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_addr_data: got %h/%h, required 000/00", mem_write_addr_o, mem_write_data_o);
        end
        checks++;
        if (fifo_count_o !== 3'd0 || busy_o !== 1'b0 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got count=%0d busy=%b ovf=%b, required 0/0/0",
                     fifo_count_o, busy_o, overflow_o);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int p0;
        mem_grant_i = 1'b1;
        p0 = pulses;
        cpu_wr(2'd0, 8'h10, 1'b0);
        cpu_wr(2'd1, 8'h01, 1'b0);
        cpu_wr(2'd2, 8'hAB, 1'b1);
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_drain: got queue=%0d busy=%b, required drained", sbq.size(), busy_o);
        end
        checks++;
        if (pulses - p0 != 1 || mem_write_addr_o !== 10'h110 || mem_write_data_o !== 8'hAB) begin
            errors++;
            $display("FAIL basic_write: got pulses=%0d addr=%h data=%h, required 1/110/AB",
                     pulses - p0, mem_write_addr_o, mem_write_data_o);
        end
    endtask

    task automatic test_step_wrap();
        bit ok;
        int p0;
        mem_grant_i = 1'b1;
        p0 = pulses;
        cpu_wr(2'd3, 8'h04, 1'b0);
        cpu_wr(2'd0, 8'hFC, 1'b0);
        cpu_wr(2'd1, 8'h03, 1'b0);
        cpu_wr(2'd2, 8'h01, 1'b1);
        cpu_wr(2'd2, 8'h02, 1'b1);
        wait_drain(ok);
        checks++;
        if (!ok || pulses - p0 != 2 || mem_write_addr_o !== 10'h000 || mem_write_data_o !== 8'h02) begin
            errors++;
            $display("FAIL step_wrap: got ok=%b pulses=%0d addr=%h data=%h, required 1/2/000/02",
                     ok, pulses - p0, mem_write_addr_o, mem_write_data_o);
        end
        cpu_wr(2'd3, 8'h01, 1'b0);
    endtask

    task automatic test_overflow();
        bit ok;
        int p0;
        mem_grant_i = 1'b0;
        p0 = pulses;
        for (int i = 0; i < 5; i++) begin
            cpu_wr(2'd2, 8'h11 + 8'(i), i < 4);
        end
        #1;
        checks++;
        if (fifo_count_o !== 3'd4 || overflow_o !== 1'b1 || busy_o !== 1'b1 || pulses != p0) begin
            errors++;
            $display("FAIL stall_full: got count=%0d ovf=%b busy=%b pulses=%0d, required 4/1/1/0",
                     fifo_count_o, overflow_o, busy_o, pulses - p0);
        end
        @(negedge clk_i);
        mem_grant_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i);
            #1;
            checks++;
            if (mem_write_enable_o !== 1'b1) begin
                errors++;
                $display("FAIL drain_consecutive[%0d]: got we=%b, required 1", i, mem_write_enable_o);
            end
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (mem_write_enable_o !== 1'b0 || fifo_count_o !== 3'd0) begin
            errors++;
            $display("FAIL drain_done: got we=%b count=%0d, required 0/0", mem_write_enable_o, fifo_count_o);
        end
        cpu_wr(2'd0, 8'h00, 1'b0);
        #1;
        checks++;
        if (overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: got %b, required 0", overflow_o);
        end
    endtask

    task automatic test_full_pop();
        bit ok;
        mem_grant_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_wr(2'd2, 8'h21 + 8'(i), 1'b1);
        end
        @(negedge clk_i);
        mem_grant_i = 1'b1;
        cpu_reg_i   = 2'd2;
        cpu_data_i  = 8'h77;
        cpu_write_i = 1'b1;
        @(posedge clk_i);
        #1;
        checks++;
        if (overflow_o !== 1'b1 || fifo_count_o !== 3'd3 || mem_write_enable_o !== 1'b1) begin
            errors++;
            $display("FAIL full_pop: got ovf=%b count=%0d we=%b, required 1/3/1",
                     overflow_o, fifo_count_o, mem_write_enable_o);
        end
        @(negedge clk_i);
        cpu_write_i = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL full_pop_drain: got queue=%0d busy=%b, required drained", sbq.size(), busy_o);
        end
    endtask

    task automatic test_ptr_change();
        bit ok;
        mem_grant_i = 1'b0;
        cpu_wr(2'd0, 8'h20, 1'b0);
        cpu_wr(2'd1, 8'h00, 1'b0);
        cpu_wr(2'd2, 8'h5A, 1'b1);
        cpu_wr(2'd0, 8'h80, 1'b0);
        repeat (3) @(negedge clk_i);
        mem_grant_i = 1'b1;
        wait_drain(ok);
        checks++;
        if (!ok || mem_write_addr_o !== 10'h020 || mem_write_data_o !== 8'h5A) begin
            errors++;
            $display("FAIL ptr_change: got ok=%b addr=%h data=%h, required 1/020/5A",
                     ok, mem_write_addr_o, mem_write_data_o);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int p0;
        mem_grant_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cpu_wr(2'd2, 8'h31 + 8'(i), 1'b1);
        end
        @(negedge clk_i);
        mem_grant_i = 1'b1;
        @(posedge clk_i);
        #2;
        reset_n_i = 1'b0;
        #1;
        sbq.delete();
        model_ptr  = 10'h000;
        model_step = 8'h01;
        checks++;
        if (mem_write_enable_o !== 1'b0 || fifo_count_o !== 3'd0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got we=%b count=%0d busy=%b, required 0/0/0",
                     mem_write_enable_o, fifo_count_o, busy_o);
        end
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        p0 = pulses;
        repeat (8) @(negedge clk_i);
        checks++;
        if (pulses != p0) begin
            errors++;
            $display("FAIL reset_mid_no_pulse: got %0d pulses, required 0", pulses - p0);
        end
        cpu_wr(2'd2, 8'hC1, 1'b1);
        cpu_wr(2'd2, 8'hC2, 1'b1);
        wait_drain(ok);
        checks++;
        if (!ok || pulses - p0 != 2 || mem_write_addr_o !== 10'h001 || mem_write_data_o !== 8'hC2) begin
            errors++;
            $display("FAIL reset_mid_defaults: got ok=%b pulses=%0d addr=%h data=%h, required 1/2/001/C2",
                     ok, pulses - p0, mem_write_addr_o, mem_write_data_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_step_wrap();
        test_overflow();
        test_full_pop();
        test_ptr_change();
        test_reset_mid();
        repeat (2) @(negedge clk_i);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: got %0d outstanding, required 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vram_write_port.md
Name: vram_write_port

Overview:
- CPU-facing write front end for the GPU's dual-port video/tile memory; drives that memory's write port (write_addr, write_enable, write_data).
- The CPU programs a VRAM address pointer through small registers, then streams data bytes.
- Each byte is queued with its address in a small FIFO and drained into memory only in cycles when the display fetcher grants write access.
- The pointer auto-increments by a programmable step.

Parameters:
- ADDRESS_WIDTH, 10, memory address width in bits; legal range 9..16.
- DATA_WIDTH, 8, memory data width; fixed at 8 because CPU data is 8 bits.
- FIFO_DEPTH_LOG2, 2, log2 of queue depth (default 4 entries).

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cpu_reg  input  2  register select: 0=ADDR_LO, 1=ADDR_HI, 2=DATA, 3=STEP.
- cpu_data  input  8  CPU write data.
- cpu_write  input  1  one-cycle write strobe, synchronous to clk.
- mem_grant  input  1  memory write slot available this cycle.
- mem_write_addr  output  ADDRESS_WIDTH  to memory write_addr.
- mem_write_enable  output  1  to memory write_enable.
- mem_write_data  output  DATA_WIDTH  to memory write_data.
- fifo_count  output  FIFO_DEPTH_LOG2+1  entries currently queued.
- busy  output  1  high while fifo_count != 0.
- overflow  output  1  sticky: a DATA write was dropped.

Behaviour:
- Reset (async assert, sync release):
  - ptr=0, step=1, FIFO emptied, fifo_count=0.
  - mem_write_enable=0, mem_write_addr=0, mem_write_data=0, busy=0, overflow=0.
  - Reset mid-operation discards all queued writes; no partial write is issued.
- ADDR_LO write: ptr[7:0] <= cpu_data. Sets overflow=0.
- ADDR_HI write: ptr[ADDRESS_WIDTH-1:8] <= cpu_data[ADDRESS_WIDTH-9:0]; higher cpu_data bits are ignored.
- STEP write: step <= cpu_data. step=0 is legal and repeatedly writes the same address.
- DATA write:
  - If FIFO is not full: push {ptr, cpu_data}; ptr <= (ptr + step) mod 2^ADDRESS_WIDTH (wraps, no flag).
  - If FIFO is full: byte dropped, ptr unchanged, overflow <= 1.
  - Fullness is sampled before any same-cycle pop. A write to a full FIFO is dropped even if a pop occurs that cycle.
- Queued entries keep the address captured at push time. Later pointer writes do not affect them.
- Drain, evaluated each cycle with registered outputs:
  - If FIFO is non-empty and mem_grant=1: at the edge, mem_write_enable<=1, mem_write_addr/mem_write_data<=head entry, head popped.
  - Otherwise mem_write_enable<=0. mem_write_addr/mem_write_data hold their last values.
- Latency:
  - A DATA write sampled at edge k is pushed at edge k.
  - Earliest mem_write_enable pulse is the cycle after edge k+1 (needs mem_grant=1 in cycle k+1).
  - No bypass from CPU to memory when the FIFO is empty.
- Simultaneous push and pop: both occur; fifo_count unchanged. Order is strictly FIFO.
- fifo_count and busy reflect state after the edge. busy = (fifo_count != 0).
- mem_grant low for any length: entries wait indefinitely and nothing is lost, except overflow drops on further DATA writes.
- Each mem_write_enable pulse corresponds to exactly one queued entry. There are never two pulses for one entry.

Test Plan:
- Basic write: ADDR_LO=0x10, ADDR_HI=0x01, DATA=0xAB with mem_grant=1 -> one pulse, addr=0x110, data=0xAB; busy back to 0.
- Auto-increment and step: STEP=4, ptr=0x3FC, DATA 0x01,0x02 -> writes to 0x3FC then 0x000 (10-bit wrap).
- Stall and overflow: mem_grant=0, DATA 0x11..0x15 -> fifo_count=4, overflow=1, 0x15 dropped. Then mem_grant=1 -> four consecutive pulses, data 0x11..0x14 in order. Then ADDR_LO write -> overflow=0.
- Full with simultaneous pop: FIFO full, mem_grant=1 and DATA=0x77 in the same cycle -> 0x77 dropped, overflow=1, fifo_count=3.
- Pointer change while queued: DATA 0x5A at 0x020 held by mem_grant=0, then ADDR_LO=0x80, then grant -> write lands at 0x020.
- Reset mid-drain: 3 entries queued, reset_n pulsed low for one cycle -> mem_write_enable=0 immediately, fifo_count=0, no further pulses, step=1, ptr=0.
